cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle control FSM for the RV32I core. Fetches each instruction over one
//  shared memory port, latches it for the combinational instruction decoder, runs any
//  load/store the decoder requests on the same port, then retires: commits PC and
//  gates the register-file write strobe. Watchdogs unanswered memory requests.
// PARAMETERS
//  RESET_PC        32'h0000_0000  PC value loaded on reset
//  TIMEOUT_CYCLES  255            request cycles without ack before FAULT; 0 disables
// PORTS
//  clk              in   1   clock; all state updates on rising edge
//  reset_i          in   1   synchronous, active-high reset
//  mem_req_o        out  1   memory request, held until ack
//  mem_we_o         out  1   1 = write (store) request
//  mem_addr_o       out  32  request address: pc_o in FETCH, addr_i in MEM
//  mem_ack_i        in   1   request completes in any cycle it is high with mem_req_o
//  mem_rdata_i      in   32  read data, valid with mem_ack_i
//  instr_o          out  32  latched instruction, to decoder instr_i
//  dec_en_o         out  1   decoder enable (decoder en_i)
//  next_pc_sel_i    in   2   from decoder: 00/10 pc+4, 01 pc+addr_i, 11 addr_i
//  addr_i           in   32  from decoder addr_o
//  d_we_i           in   1   from decoder: store
//  reg_in_en_i      in   1   from decoder: RF write requested
//  reg_in_source_i  in   2   from decoder: 01 = load data
//  pc_o             out  32  current PC
//  load_data_o      out  32  data latched from last MEM read
//  rf_we_o          out  1   RF write strobe, single cycle in WRITEBACK
//  retire_o         out  1   one-cycle pulse per retired instruction
//  fault_o          out  1   sticky until reset: timeout or misaligned fetch
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, MEM, WRITEBACK, FAULT. Moore outputs from state regs.
//  Reset: state=IDLE, pc_o=RESET_PC, instr_o=32'h0000_0013 (NOP), load_data_o=0,
//   timeout counter=0; all strobes 0. IDLE -> FETCH unconditionally next cycle.
//  FETCH: if pc_o[1:0]!=0 -> FAULT, no request. Else mem_req_o=1, mem_we_o=0,
//   mem_addr_o=pc_o; on ack latch mem_rdata_i into instr_o -> DECODE.
//  DECODE: dec_en_o=1 (also held in MEM, WRITEBACK). Mem op = d_we_i OR
//   (reg_in_en_i AND reg_in_source_i==01). Mem op -> MEM, else -> WRITEBACK.
//  MEM: mem_req_o=1, mem_we_o=d_we_i, mem_addr_o=addr_i; on ack, if read latch
//   mem_rdata_i into load_data_o -> WRITEBACK.
//  WRITEBACK: rf_we_o=reg_in_en_i, retire_o=1; pc_o updates per next_pc_sel_i
//   (32-bit add, wrap-around modulo 2^32, no fault on wrap) -> FETCH.
//  FAULT: fault_o=1, all other strobes 0, pc_o frozen; exits only via reset.
//  Handshake: mem_req_o/addr/we stable from first request cycle until ack cycle;
//   zero-wait ack (same cycle req rises) accepted; ack with mem_req_o=0 ignored.
//  Latency, zero-wait memory: ALU/branch/jump = 3 cycles; load/store = 4 cycles.
//  Timeout: counter clears on entering FETCH/MEM, +1 per request cycle without ack;
//   ack in the TIMEOUT_CYCLES-th request cycle still succeeds; no ack then -> FAULT.
//  Reset mid-request: state->IDLE at that edge, mem_req_o low the following cycle.
// TESTING
//  Reset, RESET_PC=0 -> IDLE 1 cycle, then mem_req_o=1, mem_addr_o=0, mem_we_o=0.
//  ADDI x1,x0,5 (0x00500093), zero-wait -> retire_o 3rd cycle, rf_we_o=1, pc 0->4.
//  LW, ack after 2 wait cycles, rdata 0xDEADBEEF -> req held 3 cycles at addr_i,
//   load_data_o=0xDEADBEEF, rf_we_o=1 in WRITEBACK.
//  SW -> mem_we_o=1 in MEM, rf_we_o=0; JAL at pc 0x8, sel 01, addr_i 0x10 -> pc 0x18;
//   JALR sel 11, addr_i 0x100 -> pc 0x100.
//  No ack for 255 request cycles -> fault_o=1, mem_req_o=0, held until reset;
//   ack in 255th request cycle -> normal completion, no fault.
//  sel 11 with addr_i 0x102 -> next FETCH issues no request, fault_o=1.

Source files
------------

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/mem/writeback control FSM for the RV32I core
//
// Purpose:
//    Drives one shared memory port for both instruction fetch and data
//    load/store. Each fetched instruction is latched for the combinational
//    decoder. Any load/store the decoder asks for runs on the same port.
//    The instruction then retires: the PC is committed and the register-file
//    write strobe is gated. A memory request left unanswered for
//    TIMEOUT_CYCLES request cycles, or a misaligned fetch address, parks the
//    FSM in FAULT. Only reset leaves FAULT.
//
// Parameters:
//    RESET_PC        PC loaded on reset
//    TIMEOUT_CYCLES  request cycles without ack before FAULT (0 disables)
//
// Ports:
//    clk              in   1   clock, rising edge
//    reset_i          in   1   synchronous active-high reset
//    mem_req_o        out  1   memory request, held until ack
//    mem_we_o         out  1   1 = store request
//    mem_addr_o       out  32  pc_o during FETCH, addr_i during MEM
//    mem_ack_i        in   1   request completes when high together with mem_req_o
//    mem_rdata_i      in   32  read data, valid with mem_ack_i
//    instr_o          out  32  latched instruction for the decoder
//    dec_en_o         out  1   decoder enable (DECODE, MEM, WRITEBACK)
//    next_pc_sel_i    in   2   00/10 pc+4, 01 pc+addr_i, 11 addr_i
//    addr_i           in   32  decoder address / offset
//    d_we_i           in   1   decoder: store
//    reg_in_en_i      in   1   decoder: register-file write requested
//    reg_in_source_i  in   2   decoder: 01 selects load data
//    pc_o             out  32  current PC
//    load_data_o      out  32  data from the last MEM read
//    rf_we_o          out  1   register-file write strobe (WRITEBACK only)
//    retire_o         out  1   one-cycle pulse per retired instruction
//    fault_o          out  1   sticky fault flag, cleared only by reset

module cpu_sequencer #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] instr_o,
   output logic        dec_en_o,
   input  logic [1:0]  next_pc_sel_i,
   input  logic [31:0] addr_i,
   input  logic        d_we_i,
   input  logic        reg_in_en_i,
   input  logic [1:0]  reg_in_source_i,
   output logic [31:0] pc_o,
   output logic [31:0] load_data_o,
   output logic        rf_we_o,
   output logic        retire_o,
   output logic        fault_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEM,
      S_WRITEBACK,
      S_FAULT
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   state_t      state;
   logic [31:0] timeout_cnt;
   logic [31:0] next_pc;
   logic        mem_op;
   logic        timed_out;

   // PC successor. Plain 32-bit adds wrap silently modulo 2^32.
   always_comb begin
      next_pc = pc_o + 32'd4;
      case (next_pc_sel_i)
         2'b01:   next_pc = pc_o + addr_i;
         2'b11:   next_pc = addr_i;
         default: next_pc = pc_o + 32'd4;
      endcase
   end

   assign mem_op = d_we_i | (reg_in_en_i & (reg_in_source_i == 2'b01));

   // The counter holds (request cycles so far - 1). So a count of
   // TIMEOUT_CYCLES-1 marks the last request cycle that may still be acked.
   assign timed_out = (TIMEOUT_CYCLES != 0) &&
                      (timeout_cnt == TIMEOUT_CYCLES - 32'd1);

   // All outputs are registered. Each is loaded on the edge that enters the
   // state where it must be valid, so it is already driven in the first cycle
   // of that state. This is what allows a zero-wait ack in the same cycle the
   // request rises.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         state       <= S_IDLE;
         pc_o        <= RESET_PC;
         instr_o     <= NOP_INSTR;
         load_data_o <= 32'h0;
         timeout_cnt <= 32'h0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= RESET_PC;
         dec_en_o    <= 1'b0;
         rf_we_o     <= 1'b0;
         retire_o    <= 1'b0;
         fault_o     <= 1'b0;
      end else begin
         rf_we_o  <= 1'b0;
         retire_o <= 1'b0;

         case (state)
            S_IDLE: begin
               state       <= S_FETCH;
               mem_req_o   <= (pc_o[1:0] == 2'b00);
               mem_we_o    <= 1'b0;
               mem_addr_o  <= pc_o;
               timeout_cnt <= 32'h0;
            end

            S_FETCH: begin
               if (pc_o[1:0] != 2'b00) begin
                  // No request was raised for a misaligned PC.
                  state     <= S_FAULT;
                  fault_o   <= 1'b1;
                  mem_req_o <= 1'b0;
               end else if (mem_ack_i) begin
                  instr_o   <= mem_rdata_i;
                  mem_req_o <= 1'b0;
                  dec_en_o  <= 1'b1;
                  state     <= S_DECODE;
               end else if (timed_out) begin
                  state     <= S_FAULT;
                  fault_o   <= 1'b1;
                  mem_req_o <= 1'b0;
               end else begin
                  timeout_cnt <= timeout_cnt + 32'd1;
               end
            end

            S_DECODE: begin
               if (mem_op) begin
                  state       <= S_MEM;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= d_we_i;
                  mem_addr_o  <= addr_i;
                  timeout_cnt <= 32'h0;
               end else begin
                  state    <= S_WRITEBACK;
                  rf_we_o  <= reg_in_en_i;
                  retire_o <= 1'b1;
               end
            end

            S_MEM: begin
               if (mem_ack_i) begin
                  if (!mem_we_o) begin
                     load_data_o <= mem_rdata_i;
                  end
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  state     <= S_WRITEBACK;
                  rf_we_o   <= reg_in_en_i;
                  retire_o  <= 1'b1;
               end else if (timed_out) begin
                  state     <= S_FAULT;
                  fault_o   <= 1'b1;
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  dec_en_o  <= 1'b0;
               end else begin
                  timeout_cnt <= timeout_cnt + 32'd1;
               end
            end

            S_WRITEBACK: begin
               // The alignment of the new PC decides here whether the coming
               // FETCH raises a request at all.
               pc_o        <= next_pc;
               state       <= S_FETCH;
               dec_en_o    <= 1'b0;
               mem_req_o   <= (next_pc[1:0] == 2'b00);
               mem_we_o    <= 1'b0;
               mem_addr_o  <= next_pc;
               timeout_cnt <= 32'h0;
            end

            S_FAULT: begin
               fault_o   <= 1'b1;
               mem_req_o <= 1'b0;
               mem_we_o  <= 1'b0;
               dec_en_o  <= 1'b0;
            end

            default: begin
               state     <= S_FAULT;
               fault_o   <= 1'b1;
               mem_req_o <= 1'b0;
               mem_we_o  <= 1'b0;
               dec_en_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam int          TIMEOUT = 255;

   logic        clk;
   logic        reset_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] instr_o;
   logic        dec_en_o;
   logic [1:0]  next_pc_sel_i;
   logic [31:0] addr_i;
   logic        d_we_i;
   logic        reg_in_en_i;
   logic [1:0]  reg_in_source_i;
   logic [31:0] pc_o;
   logic [31:0] load_data_o;
   logic        rf_we_o;
   logic        retire_o;
   logic        fault_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] m_pc;
   logic [31:0] m_load;

   cpu_sequencer #(
      .RESET_PC       (RST_PC),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk             (clk),
      .reset_i         (reset_i),
      .mem_req_o       (mem_req_o),
      .mem_we_o        (mem_we_o),
      .mem_addr_o      (mem_addr_o),
      .mem_ack_i       (mem_ack_i),
      .mem_rdata_i     (mem_rdata_i),
      .instr_o         (instr_o),
      .dec_en_o        (dec_en_o),
      .next_pc_sel_i   (next_pc_sel_i),
      .addr_i          (addr_i),
      .d_we_i          (d_we_i),
      .reg_in_en_i     (reg_in_en_i),
      .reg_in_source_i (reg_in_source_i),
      .pc_o            (pc_o),
      .load_data_o     (load_data_o),
      .rf_we_o         (rf_we_o),
      .retire_o        (retire_o),
      .fault_o         (fault_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   // Serve one request: ack arrives in request cycle wait_n+1. Entered and
   // left on a falling edge.
   task automatic do_req(input logic [31:0] exp_addr, input logic exp_we, input int wait_n,
                         input logic [31:0] rdata, input string nm);
      for (int c = 0; c <= wait_n; c++) begin
         checks++;
         if ({mem_req_o, mem_we_o, mem_addr_o, fault_o} !== {1'b1, exp_we, exp_addr, 1'b0}) begin
            errors++;
            $display("FAIL %s req cycle %0d: req/we/addr/fault got %b/%b/%h/%b want 1/%b/%h/0",
                     nm, c + 1, mem_req_o, mem_we_o, mem_addr_o, fault_o, exp_we, exp_addr);
         end
         mem_ack_i   = (c == wait_n);
         mem_rdata_i = (c == wait_n) ? rdata : $urandom;
         @(negedge clk);
      end
      mem_ack_i = 1'b0;
   endtask

   // One complete instruction starting in its FETCH cycle.
   // kind: 0 ALU, 1 LOAD, 2 STORE, 3 JAL, 4 JALR, 5 taken branch, 6 not-taken branch
   task automatic run_instr(input int kind, input logic [31:0] instr, input logic [31:0] addr,
                            input logic [31:0] rdata, input int fw, input int mw, input string nm);
      logic [1:0] sel;
      logic       we, ren, memop;
      logic [1:0] src;
      int         start, exp_lat;
      sel = 2'b00; we = 1'b0; ren = 1'b0; src = 2'b00;
      case (kind)
         0: begin ren = 1'b1; end
         1: begin ren = 1'b1; src = 2'b01; end
         2: begin we = 1'b1; end
         3: begin sel = 2'b01; ren = 1'b1; src = 2'b10; end
         4: begin sel = 2'b11; ren = 1'b1; src = 2'b10; end
         5: begin sel = 2'b01; src = 2'b01; end
         default: begin sel = 2'b10; end
      endcase
      next_pc_sel_i = sel; addr_i = addr; d_we_i = we;
      reg_in_en_i = ren; reg_in_source_i = src;
      memop = we | (ren && src == 2'b01);
      start = cyc;

      do_req(m_pc, 1'b0, fw, instr, {nm, " fetch"});
      checks++;
      if ({dec_en_o, mem_req_o, retire_o, instr_o} !== {1'b1, 1'b0, 1'b0, instr}) begin
         errors++;
         $display("FAIL %s decode: dec_en/req/retire/instr got %b/%b/%b/%h want 1/0/0/%h",
                  nm, dec_en_o, mem_req_o, retire_o, instr_o, instr);
      end
      @(negedge clk);

      if (memop) begin
         do_req(addr, we, mw, rdata, {nm, " mem"});
         if (!we) m_load = rdata;
      end

      exp_lat = 3 + fw + (memop ? mw + 1 : 0);
      checks++;
      if ({retire_o, rf_we_o, dec_en_o, mem_req_o, load_data_o, pc_o} !==
          {1'b1, ren, 1'b1, 1'b0, m_load, m_pc} || (cyc - start + 1) != exp_lat) begin
         errors++;
         $display("FAIL %s writeback: retire/rf_we/dec_en/req %b%b%b%b load %h pc %h lat %0d want 1%b10 %h %h lat %0d",
                  nm, retire_o, rf_we_o, dec_en_o, mem_req_o, load_data_o, pc_o,
                  cyc - start + 1, ren, m_load, m_pc, exp_lat);
      end

      if (sel == 2'b01)      m_pc = m_pc + addr;
      else if (sel == 2'b11) m_pc = addr;
      else                   m_pc = m_pc + 32'd4;
      @(negedge clk);

      checks++;
      if ({pc_o, retire_o, rf_we_o, dec_en_o} !== {m_pc, 3'b000}) begin
         errors++;
         $display("FAIL %s next fetch: pc %h retire/rf_we/dec_en %b%b%b want pc %h 000",
                  nm, pc_o, retire_o, rf_we_o, dec_en_o, m_pc);
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      next_pc_sel_i = 2'b00; addr_i = 32'h0; d_we_i = 1'b0;
      reg_in_en_i = 1'b0; reg_in_source_i = 2'b00;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({mem_req_o, mem_we_o, dec_en_o, rf_we_o, retire_o, fault_o, pc_o, instr_o, load_data_o} !==
          {6'b000000, RST_PC, 32'h0000_0013, 32'h0}) begin
         errors++;
         $display("FAIL reset values: strobes %b%b%b%b%b%b pc %h instr %h load %h",
                  mem_req_o, mem_we_o, dec_en_o, rf_we_o, retire_o, fault_o, pc_o, instr_o, load_data_o);
      end
      reset_i = 1'b0;
      m_pc = RST_PC; m_load = 32'h0;
      @(negedge clk);
      checks++;
      if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, RST_PC}) begin
         errors++;
         $display("FAIL first fetch after idle: req/we/addr %b/%b/%h want 1/0/%h",
                  mem_req_o, mem_we_o, mem_addr_o, RST_PC);
      end
   endtask

   task automatic test_directed();
      test_reset();
      run_instr(0, 32'h0050_0093, 32'h0, 32'h0, 0, 0, "addi");
      run_instr(1, 32'h0000_2103, 32'h0000_0040, 32'hDEAD_BEEF, 0, 2, "lw");
      run_instr(3, 32'h0100_006F, 32'h0000_0010, 32'h0, 0, 0, "jal");
      checks++;
      if (pc_o !== 32'h0000_0018) begin
         errors++;
         $display("FAIL jal target: pc %h want 00000018", pc_o);
      end
      run_instr(2, 32'h0020_2023, 32'h0000_0044, 32'h1234_5678, 1, 0, "sw");
      run_instr(4, 32'h1000_00E7, 32'h0000_0100, 32'h0, 0, 0, "jalr");
      run_instr(5, 32'h0000_0063, 32'h0000_0008, 32'h0, 0, 0, "beq ren0 src01");
      run_instr(6, 32'h0000_1063, 32'h0000_0040, 32'h0, 0, 0, "bne not taken");
      run_instr(4, 32'h0000_0067, 32'hFFFF_FFFC, 32'h0, 0, 0, "jalr top");
      run_instr(0, 32'h0000_0013, 32'h0, 32'h0, 0, 0, "pc wrap");
   endtask

   task automatic test_random();
      int kind;
      logic [31:0] a;
      test_reset();
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 6);
         a = $urandom;
         if (kind >= 3) a = a & 32'hFFFF_FFFC;
         run_instr(kind, $urandom, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "random");
      end
   endtask

   task automatic test_timeout();
      logic [31:0] frozen;
      test_reset();
      for (int c = 0; c < TIMEOUT; c++) begin
         if (c == TIMEOUT - 1) begin
            checks++;
            if ({mem_req_o, fault_o} !== 2'b10) begin
               errors++;
               $display("FAIL timeout last request cycle: req/fault %b%b want 10", mem_req_o, fault_o);
            end
         end
         @(negedge clk);
      end
      frozen = m_pc;
      checks++;
      if ({fault_o, mem_req_o, dec_en_o, retire_o} !== 4'b1000) begin
         errors++;
         $display("FAIL timeout fault: fault/req/dec_en/retire %b%b%b%b want 1000",
                  fault_o, mem_req_o, dec_en_o, retire_o);
      end
      mem_ack_i = 1'b1; mem_rdata_i = $urandom;
      repeat (4) @(negedge clk);
      mem_ack_i = 1'b0;
      checks++;
      if ({fault_o, mem_req_o, retire_o, rf_we_o, pc_o} !== {4'b1000, frozen}) begin
         errors++;
         $display("FAIL fault sticky: fault/req/retire/rf_we %b%b%b%b pc %h want 1000 pc %h",
                  fault_o, mem_req_o, retire_o, rf_we_o, pc_o, frozen);
      end
      test_reset();
      run_instr(1, $urandom, 32'h0000_0200, 32'hCAFE_F00D, TIMEOUT - 1, 0, "ack 255th fetch");
      run_instr(2, $urandom, 32'h0000_0300, 32'h0, 0, TIMEOUT - 1, "ack 255th mem");
      checks++;
      if (fault_o !== 1'b0) begin
         errors++;
         $display("FAIL late ack fault: fault %b want 0", fault_o);
      end
   endtask

   task automatic test_misaligned();
      test_reset();
      run_instr(4, $urandom, 32'h0000_0102, 32'h0, 0, 0, "jalr misaligned");
      checks++;
      if ({mem_req_o, pc_o} !== {1'b0, 32'h0000_0102}) begin
         errors++;
         $display("FAIL misaligned fetch request: req %b pc %h want 0 00000102", mem_req_o, pc_o);
      end
      @(negedge clk);
      checks++;
      if ({fault_o, mem_req_o, pc_o} !== {2'b10, 32'h0000_0102}) begin
         errors++;
         $display("FAIL misaligned fault: fault/req %b%b pc %h want 10 00000102", fault_o, mem_req_o, pc_o);
      end
   endtask

   task automatic test_reset_mid_request();
      test_reset();
      run_instr(0, $urandom, 32'h0, 32'h0, 0, 0, "pre");
      repeat (2) @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_req_o, pc_o, fault_o} !== {1'b0, RST_PC, 1'b0}) begin
         errors++;
         $display("FAIL reset mid request: req %b pc %h fault %b want 0 %h 0", mem_req_o, pc_o, fault_o, RST_PC);
      end
      reset_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_req_o, mem_addr_o} !== {1'b1, RST_PC}) begin
         errors++;
         $display("FAIL restart after mid reset: req %b addr %h want 1 %h", mem_req_o, mem_addr_o, RST_PC);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_timeout();
      test_misaligned();
      test_reset_mid_request();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
